// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: NUM_RD synchronous read ports, two write ports.
// Optional write-first read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_req,
  output logic                     ready,
  input  logic                     we_a,
  input  logic [ADDR_W-1:0]        waddr_a,
  input  logic [DATA_W-1:0]        wdata_a,
  input  logic                     we_b,
  input  logic [ADDR_W-1:0]        waddr_b,
  input  logic [DATA_W-1:0]        wdata_b,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t                         state;
  logic [ADDR_W-1:0]              clr_ptr;
  logic [DATA_W-1:0]              mem [DEPTH];
  logic [ADDR_W-1:0]              rd_addr [NUM_RD];
  logic [NUM_RD-1:0][DATA_W-1:0]  rd_next;
  logic [NUM_RD-1:0][DATA_W-1:0]  rd_q;
  logic                           wr_a;
  logic                           wr_b;

  // A write is live only in RUN, outside a clear request, and never to a hardwired zero register.
  assign wr_a = (state == ST_RUN) && !clear_req && we_a && !((ZERO_REG != 0) && (waddr_a == '0));
  assign wr_b = (state == ST_RUN) && !clear_req && we_b && !((ZERO_REG != 0) && (waddr_b == '0));

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_addr
    assign rd_addr[k] = raddr[k*ADDR_W +: ADDR_W];
  end

  always_comb begin
    rd_next = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_next[k] = mem[rd_addr[k]];
`ifdef REGFILE_BYPASS_EN
      if (wr_a && (waddr_a == rd_addr[k])) rd_next[k] = wdata_a;
      if (wr_b && (waddr_b == rd_addr[k])) rd_next[k] = wdata_b;
`endif
      if ((ZERO_REG != 0) && (rd_addr[k] == '0)) rd_next[k] = '0;
    end
  end

  // NOTE: the storage array has no reset so it maps onto distributed RAM; the
  // CLEAR sequence zeroes it one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_ptr] <= '0;
    end else begin
      // NOTE: with non-blocking assignments the later statement wins, which
      // gives port B priority when both ports hit the same address.
      if (wr_a) mem[waddr_a] <= wdata_a;
      if (wr_b) mem[waddr_b] <= wdata_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
      rd_q    <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          rd_q    <= '0;
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_ADDR) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_RUN: begin
          rd_q <= rd_next;
          if (clear_req) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
            ready   <= 1'b0;
          end
        end
        default: begin
          state   <= ST_CLEAR;
          clr_ptr <= '0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

  assign rdata = rd_q;

endmodule
